// File: rtl/timer_irq_master.sv
// timer_irq_master: Avalon-MM master that enables the interval-timer IRQ, acknowledges each timeout
// and emits a divided tick. Define TIMER_MASTER_SNAP_EN to add the snapshot read-back sequence.
//
// state      | meaning
// S_OFF      | service disabled, no bus activity
// S_CTRL_ON  | write control = 1 (IRQ enable)
// S_IDLE     | enabled, waiting for irq or en drop
// S_ACK      | write status = 0 (clear timeout flag)
// S_SNAP_WR  | write snapshot register (latch counter)
// S_SNAP_RD  | read snapshot register
// S_SNAP_CAP | capture m_readdata into snap_value
// S_TICK     | advance divider, pulse tick on terminal count
// S_CTRL_OFF | write control = 0
module timer_irq_master #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             irq,
  output logic [2:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [15:0]      m_writedata,
  input  logic [15:0]      m_readdata,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             busy,
  output logic [15:0]      snap_value,
  output logic             snap_valid
);

  typedef enum logic [3:0] {
    S_OFF, S_CTRL_ON, S_IDLE, S_ACK, S_TICK, S_CTRL_OFF
`ifdef TIMER_MASTER_SNAP_EN
    , S_SNAP_WR, S_SNAP_RD, S_SNAP_CAP
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] tick_count_q, tick_count_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             m_cs_q, m_cs_d;
  logic             m_wn_q, m_wn_d;
  logic [2:0]       m_addr_q, m_addr_d;
  logic [15:0]      m_wd_q, m_wd_d;
  logic             div_term;

`ifdef TIMER_MASTER_SNAP_EN
  logic [15:0]      snap_value_q, snap_value_d;
  logic             snap_valid_q, snap_valid_d;
`endif

  assign div_term = (div_cnt_q == 16'(TICK_DIV - 1));

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    tick_count_d = tick_count_q;
`ifdef TIMER_MASTER_SNAP_EN
    snap_value_d = snap_value_q;
    snap_valid_d = 1'b0;
`endif
    case (state_q)
      S_OFF:     if (en) state_d = S_CTRL_ON;
      S_CTRL_ON: state_d = S_IDLE;
      // en low wins over a coincident irq; the flag stays pending in the timer
      S_IDLE: begin
        if (!en)      state_d = S_CTRL_OFF;
        else if (irq) state_d = S_ACK;
      end
`ifdef TIMER_MASTER_SNAP_EN
      S_ACK:     state_d = S_SNAP_WR;
      S_SNAP_WR: state_d = S_SNAP_RD;
      S_SNAP_RD: state_d = S_SNAP_CAP;
      S_SNAP_CAP: begin
        state_d      = S_TICK;
        snap_value_d = m_readdata;
        snap_valid_d = 1'b1;
      end
`else
      S_ACK:     state_d = S_TICK;
`endif
      S_TICK: begin
        state_d = S_IDLE;
        if (div_term) begin
          div_cnt_d    = '0;
          tick_count_d = tick_count_q + CNT_W'(1);
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      S_CTRL_OFF: state_d = S_OFF;
      default:    state_d = S_OFF;
    endcase

    // Outputs are registered from the next state so they track the state register exactly.
    m_cs_d   = 1'b0;
    m_wn_d   = 1'b1;
    m_addr_d = 3'd0;
    m_wd_d   = 16'h0000;
    case (state_d)
      S_CTRL_ON:  begin m_cs_d = 1'b1; m_wn_d = 1'b0; m_addr_d = 3'd1; m_wd_d = 16'h0001; end
      S_ACK:      begin m_cs_d = 1'b1; m_wn_d = 1'b0; m_addr_d = 3'd0; end
      S_CTRL_OFF: begin m_cs_d = 1'b1; m_wn_d = 1'b0; m_addr_d = 3'd1; end
`ifdef TIMER_MASTER_SNAP_EN
      S_SNAP_WR:  begin m_cs_d = 1'b1; m_wn_d = 1'b0; m_addr_d = 3'd4; end
      S_SNAP_RD:  begin m_cs_d = 1'b1; m_addr_d = 3'd4; end
`endif
      default: ;
    endcase
    tick_d = (state_d == S_TICK) && div_term;
    busy_d = (state_d != S_OFF) && (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_OFF;
      div_cnt_q    <= '0;
      tick_count_q <= '0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      m_cs_q       <= 1'b0;
      m_wn_q       <= 1'b1;
      m_addr_q     <= 3'd0;
      m_wd_q       <= 16'h0000;
`ifdef TIMER_MASTER_SNAP_EN
      snap_value_q <= 16'h0000;
      snap_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      tick_count_q <= tick_count_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      m_cs_q       <= m_cs_d;
      m_wn_q       <= m_wn_d;
      m_addr_q     <= m_addr_d;
      m_wd_q       <= m_wd_d;
`ifdef TIMER_MASTER_SNAP_EN
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
`endif
    end
  end

  assign m_address    = m_addr_q;
  assign m_chipselect = m_cs_q;
  assign m_write_n    = m_wn_q;
  assign m_writedata  = m_wd_q;
  assign tick         = tick_q;
  assign tick_count   = tick_count_q;
  assign busy         = busy_q;

`ifdef TIMER_MASTER_SNAP_EN
  assign snap_value = snap_value_q;
  assign snap_valid = snap_valid_q;
`else
  logic unused_readdata;
  assign unused_readdata = ^m_readdata;
  assign snap_value      = 16'h0000;
  assign snap_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_timer_irq_master.sv
// Bench for timer_irq_master: directed scenarios plus a randomized run against a
// transaction-schedule reference model, with a behavioural interval-timer slave.
`timescale 1ns/1ps
module tb_timer_irq_master;

`ifdef TIMER_MASTER_SNAP_EN
  localparam int TOFS   = 5;
  localparam int RST_AT = 3;
`else
  localparam int TOFS   = 2;
  localparam int RST_AT = 1;
`endif
  localparam int RN = 1500;
  localparam int RA = RN + 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        irq;
  logic        timeout = 1'b0;
  logic [15:0] snap_src = 16'h0000;
  logic [15:0] m_readdata;

  logic [2:0]  m_address,  b_address;
  logic        m_chipselect, b_chipselect;
  logic        m_write_n,  b_write_n;
  logic [15:0] m_writedata, b_writedata;
  logic        tick3, tick1, busy, busy1;
  logic [31:0] tick_count3;
  logic [1:0]  tick_count1;
  logic [15:0] snap_value, snap_value1;
  logic        snap_valid, snap_valid1;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;

  logic        flag, ctl;
  logic [15:0] snap_reg;

  logic        e_cs[RA], e_wn[RA], e_busy[RA], e_t1[RA], e_t3[RA], e_sv[RA], inc1[RA], inc3[RA];
  logic [2:0]  e_addr[RA];
  logic [15:0] e_wd[RA], shist[RA];

  always #5 clk = ~clk;

  timer_irq_master #(.TICK_DIV(3), .CNT_W(32)) dut3 (
    .clk(clk), .reset_n(reset_n), .en(en), .irq(irq),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata),
    .tick(tick3), .tick_count(tick_count3), .busy(busy),
    .snap_value(snap_value), .snap_valid(snap_valid));

  // Second instance: divide-by-one and a 2-bit counter so wrap-around is reachable.
  timer_irq_master #(.TICK_DIV(1), .CNT_W(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .irq(irq),
    .m_address(b_address), .m_chipselect(b_chipselect), .m_write_n(b_write_n),
    .m_writedata(b_writedata), .m_readdata(m_readdata),
    .tick(tick1), .tick_count(tick_count1), .busy(busy1),
    .snap_value(snap_value1), .snap_valid(snap_valid1));

  // Interval-timer slave: sticky timeout flag, IRQ enable, snapshot latch, registered read data.
  always @(posedge clk) begin
    if (!reset_n) begin
      flag <= 1'b0; ctl <= 1'b0; snap_reg <= 16'h0000; m_readdata <= 16'h0000;
    end else begin
      if (m_chipselect && !m_write_n) begin
        if (m_address == 3'd0) begin flag <= 1'b0; ack_cnt <= ack_cnt + 1; end
        if (m_address == 3'd1) ctl <= m_writedata[0];
        if (m_address == 3'd4) snap_reg <= snap_src;
      end
      if (timeout) flag <= 1'b1;
      m_readdata <= (m_chipselect && m_write_n && m_address == 3'd4) ? snap_reg : 16'h0000;
    end
  end
  assign irq = flag & ctl;

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; timeout = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (m_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs cyc %0d: got %b want 0", i, m_chipselect); end
    end
    n_checks++;
    if ({m_write_n, m_address, m_writedata} !== {1'b1, 3'd0, 16'h0000}) begin
      n_fail++; $display("FAIL reset_bus: got wn=%b a=%0d d=%h want wn=1 a=0 d=0", m_write_n, m_address, m_writedata);
    end
    n_checks++;
    if ({tick3, tick1, busy, busy1} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got tick3=%b tick1=%b busy=%b busy1=%b want 0", tick3, tick1, busy, busy1);
    end
    n_checks++;
    if (tick_count3 !== 32'd0 || tick_count1 !== 2'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d/%0d want 0/0", tick_count3, tick_count1);
    end
    n_checks++;
    if (snap_value !== 16'h0000 || snap_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_snap: got %h/%b want 0/0", snap_value, snap_valid);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_enable();
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m_chipselect, m_write_n, m_address, m_writedata, busy} !== {1'b1, 1'b0, 3'd1, 16'h0001, 1'b1}) begin
      n_fail++; $display("FAIL ctrl_on: got cs=%b wn=%b a=%0d d=%h busy=%b want 1 0 1 0001 1",
                         m_chipselect, m_write_n, m_address, m_writedata, busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (m_chipselect !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL after_ctrl_on cyc %0d: got cs=%b busy=%b want 0 0", i, m_chipselect, busy);
      end
    end
  endtask

  task automatic test_single_irq();
    int a0;
    logic [1:0]  c1;
    logic [31:0] c3;
    a0 = ack_cnt; c1 = tick_count1; c3 = tick_count3;
    timeout = 1'b1;
    @(negedge clk);
    timeout = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b0, 3'd0, 16'h0000}) begin
      n_fail++; $display("FAIL ack_write: got cs=%b wn=%b a=%0d d=%h want 1 0 0 0000", m_chipselect, m_write_n, m_address, m_writedata);
    end
    repeat (TOFS - 2) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (tick1 !== 1'b1 || tick3 !== 1'b0 || tick_count1 !== c1) begin
      n_fail++; $display("FAIL tick_cycle: got tick1=%b tick3=%b cnt1=%0d want 1 0 %0d", tick1, tick3, tick_count1, c1);
    end
    @(negedge clk);
    n_checks++;
    if (tick_count1 !== c1 + 2'd1 || tick1 !== 1'b0 || busy !== 1'b0 || tick_count3 !== c3) begin
      n_fail++; $display("FAIL after_tick: got cnt1=%0d tick1=%b busy=%b cnt3=%0d want %0d 0 0 %0d",
                         tick_count1, tick1, busy, tick_count3, c1 + 2'd1, c3);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (ack_cnt !== a0 + 1) begin n_fail++; $display("FAIL ack_once: got %0d acks want 1", ack_cnt - a0); end
  endtask

  task automatic test_div3();
    for (int k = 0; k < 2; k++) begin
      timeout = 1'b1;
      @(negedge clk);
      timeout = 1'b0;
      repeat (TOFS) @(negedge clk);
      n_checks++;
      if (tick3 !== (k == 1) || tick1 !== 1'b1) begin
        n_fail++; $display("FAIL div3_tick svc %0d: got tick3=%b tick1=%b want %b 1", k + 2, tick3, tick1, (k == 1));
      end
      @(negedge clk);
    end
    n_checks++;
    if (tick_count3 !== 32'd1 || tick_count1 !== 2'd3) begin
      n_fail++; $display("FAIL div3_count: got %0d/%0d want 1/3", tick_count3, tick_count1);
    end
  endtask

  task automatic test_en_off_irq();
    int a0;
    logic [31:0] c3;
    a0 = ack_cnt; c3 = tick_count3;
    timeout = 1'b1;
    @(negedge clk);
    timeout = 1'b0;
    en = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0000}) begin
      n_fail++; $display("FAIL ctrl_off: got cs=%b wn=%b a=%0d d=%h want 1 0 1 0000", m_chipselect, m_write_n, m_address, m_writedata);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || m_chipselect !== 1'b0) begin n_fail++; $display("FAIL off_idle: got busy=%b cs=%b want 0 0", busy, m_chipselect); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (ack_cnt !== a0 || tick_count3 !== c3) begin
      n_fail++; $display("FAIL off_no_ack: got acks=%0d cnt3=%0d want 0 %0d", ack_cnt - a0, tick_count3, c3);
    end
  endtask

  task automatic test_reenable();
    en = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0001}) begin
      n_fail++; $display("FAIL reen_ctrl_on: got cs=%b wn=%b a=%0d d=%h want 1 0 1 0001", m_chipselect, m_write_n, m_address, m_writedata);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({m_chipselect, m_write_n, m_address} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL reen_pending_ack: got cs=%b wn=%b a=%0d want 1 0 0", m_chipselect, m_write_n, m_address);
    end
    repeat (TOFS) @(negedge clk);
    n_checks++;
    if (tick_count1 !== 2'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL count_wrap: got cnt1=%0d busy=%b want 0 0", tick_count1, busy);
    end
  endtask

  task automatic test_snap();
    snap_src = 16'h1234;
    timeout = 1'b1;
    @(negedge clk);
    timeout = 1'b0;
`ifdef TIMER_MASTER_SNAP_EN
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({m_chipselect, m_write_n, m_address} !== {1'b1, 1'b0, 3'd4}) begin
      n_fail++; $display("FAIL snap_wr: got cs=%b wn=%b a=%0d want 1 0 4", m_chipselect, m_write_n, m_address);
    end
    @(negedge clk);
    n_checks++;
    if ({m_chipselect, m_write_n, m_address} !== {1'b1, 1'b1, 3'd4}) begin
      n_fail++; $display("FAIL snap_rd: got cs=%b wn=%b a=%0d want 1 1 4", m_chipselect, m_write_n, m_address);
    end
    @(negedge clk);
    n_checks++;
    if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL snap_early: got valid=%b want 0", snap_valid); end
    @(negedge clk);
    n_checks++;
    if (snap_valid !== 1'b1 || snap_value !== 16'h1234) begin
      n_fail++; $display("FAIL snap_cap: got valid=%b val=%h want 1 1234", snap_valid, snap_value);
    end
    @(negedge clk);
    n_checks++;
    if (snap_valid !== 1'b0 || snap_value !== 16'h1234) begin
      n_fail++; $display("FAIL snap_hold: got valid=%b val=%h want 0 1234", snap_valid, snap_value);
    end
`else
    for (int i = 0; i < TOFS + 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (snap_valid !== 1'b0 || snap_value !== 16'h0000) begin
        n_fail++; $display("FAIL snap_off cyc %0d: got valid=%b val=%h want 0 0000", i, snap_valid, snap_value);
      end
    end
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    timeout = 1'b1;
    @(negedge clk);
    timeout = 1'b0;
    repeat (RST_AT) @(negedge clk);
    n_checks++;
    if (m_chipselect !== 1'b1) begin n_fail++; $display("FAIL mid_access: got cs=%b want 1", m_chipselect); end
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_chipselect, busy, snap_valid, tick3} !== 4'b0000 || tick_count3 !== 32'd0 || tick_count1 !== 2'd0) begin
      n_fail++; $display("FAIL mid_reset: got cs=%b busy=%b sv=%b tick=%b cnt=%0d/%0d want all 0",
                         m_chipselect, busy, snap_valid, tick3, tick_count3, tick_count1);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Reference model: each decision point (OFF/IDLE) schedules the exact future bus
  // transactions, busy window, tick cycle and counter increments of the resulting sequence.
  task automatic test_random();
    bit on;
    int free_at, svc, tc;
    logic [31:0] c3;
    logic [1:0]  c1;
    logic [15:0] sv_exp;
    for (int i = 0; i < RA; i++) begin
      e_cs[i] = 0; e_wn[i] = 1; e_addr[i] = 0; e_wd[i] = 0; e_busy[i] = 0;
      e_t1[i] = 0; e_t3[i] = 0; e_sv[i] = 0; inc1[i] = 0; inc3[i] = 0; shist[i] = 0;
    end
    on = 0; free_at = 0; svc = 0; c3 = 0; c1 = 0; sv_exp = 0;
    reset_n = 1'b0; en = 1'b0; timeout = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < RN; c++) begin
      @(negedge clk);
      if (inc1[c]) c1 = c1 + 2'd1;
      if (inc3[c]) c3 = c3 + 32'd1;
      if (e_sv[c]) sv_exp = shist[c-3];
      n_checks++;
      if ({m_chipselect, m_write_n, m_address, m_writedata} !== {e_cs[c], e_wn[c], e_addr[c], e_wd[c]}) begin
        n_fail++; $display("FAIL rnd_bus c%0d: got cs=%b wn=%b a=%0d d=%h want %b %b %0d %h", c,
                           m_chipselect, m_write_n, m_address, m_writedata, e_cs[c], e_wn[c], e_addr[c], e_wd[c]);
      end
      n_checks++;
      if ({b_chipselect, b_write_n, b_address, b_writedata} !== {e_cs[c], e_wn[c], e_addr[c], e_wd[c]}) begin
        n_fail++; $display("FAIL rnd_bus1 c%0d: got cs=%b wn=%b a=%0d d=%h", c, b_chipselect, b_write_n, b_address, b_writedata);
      end
      n_checks++;
      if (busy !== e_busy[c] || busy1 !== e_busy[c]) begin
        n_fail++; $display("FAIL rnd_busy c%0d: got %b/%b want %b", c, busy, busy1, e_busy[c]);
      end
      n_checks++;
      if (tick3 !== e_t3[c] || tick1 !== e_t1[c]) begin
        n_fail++; $display("FAIL rnd_tick c%0d: got %b/%b want %b/%b", c, tick3, tick1, e_t3[c], e_t1[c]);
      end
      n_checks++;
      if (tick_count3 !== c3 || tick_count1 !== c1) begin
        n_fail++; $display("FAIL rnd_count c%0d: got %0d/%0d want %0d/%0d", c, tick_count3, tick_count1, c3, c1);
      end
      n_checks++;
      if (snap_valid !== e_sv[c] || snap_value !== sv_exp || snap_valid1 !== e_sv[c] || snap_value1 !== sv_exp) begin
        n_fail++; $display("FAIL rnd_snap c%0d: got %b %h / %b %h want %b %h", c,
                           snap_valid, snap_value, snap_valid1, snap_value1, e_sv[c], sv_exp);
      end
      if (en) begin
        if ($urandom_range(0, 39) == 0) en = 1'b0;
      end else if ($urandom_range(0, 5) == 0) en = 1'b1;
      timeout  = ($urandom_range(0, 4) == 0);
      snap_src = 16'($urandom);
      shist[c] = snap_src;
      if (c >= free_at) begin
        if (!on) begin
          if (en) begin
            e_cs[c+1] = 1; e_wn[c+1] = 0; e_addr[c+1] = 3'd1; e_wd[c+1] = 16'h0001; e_busy[c+1] = 1;
            free_at = c + 2; on = 1;
          end
        end else if (!en) begin
          e_cs[c+1] = 1; e_wn[c+1] = 0; e_addr[c+1] = 3'd1; e_wd[c+1] = 16'h0000; e_busy[c+1] = 1;
          free_at = c + 2; on = 0;
        end else if (irq) begin
          e_cs[c+1] = 1; e_wn[c+1] = 0; e_addr[c+1] = 3'd0; e_wd[c+1] = 16'h0000;
`ifdef TIMER_MASTER_SNAP_EN
          e_cs[c+2] = 1; e_wn[c+2] = 0; e_addr[c+2] = 3'd4;
          e_cs[c+3] = 1; e_wn[c+3] = 1; e_addr[c+3] = 3'd4;
          e_sv[c+5] = 1;
`endif
          tc = c + TOFS;
          for (int k = c + 1; k <= tc; k++) e_busy[k] = 1;
          svc++;
          e_t1[tc] = 1; inc1[tc+1] = 1;
          if (svc % 3 == 0) begin e_t3[tc] = 1; inc3[tc+1] = 1; end
          free_at = tc + 1;
        end
      end
    end
    en = 1'b0; timeout = 1'b0;
  endtask

  initial begin
    test_reset();
    test_enable();
    test_single_irq();
    test_div3();
    test_en_off_irq();
    test_reenable();
    test_snap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_irq_master.md
# timer_irq_master

Avalon-MM master that services the interval-timer peripheral without CPU involvement. It enables the timer interrupt, waits for `irq`, acknowledges it by writing the status register, and emits a divided system tick with a running tick count. It sits between the timer's 16-bit register slave and the fabric logic that needs a periodic tick; it is the initiator for the timer's register port.

## Interface
- `TICK_DIV`, default 1: number of serviced interrupts per `tick` pulse; legal range 1..65535.
- `CNT_W`, default 32: width of `tick_count`.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `en` in 1: service enable.
- `irq` in 1: timer interrupt, level.
- `m_address` out 3: timer register address.
- `m_chipselect` out 1: bus access strobe.
- `m_write_n` out 1: 0 selects write, 1 selects read.
- `m_writedata` out 16: write data.
- `m_readdata` in 16: slave read data, registered by the slave, valid one cycle after address.
- `tick` out 1: one-cycle tick pulse.
- `tick_count` out CNT_W: number of `tick` pulses since reset; wraps modulo 2^CNT_W.
- `busy` out 1: high in every state except OFF and IDLE.
- `snap_value` out 16: last counter snapshot (`TIMER_MASTER_SNAP_EN` only).
- `snap_valid` out 1: one-cycle strobe for `snap_value` (`TIMER_MASTER_SNAP_EN` only).

## Operation
Timer register map used:
- 0 = status; a write clears the timeout flag.
- 1 = control; bit 0 is the IRQ enable.
- 4 = snapshot; a write latches the counter, a read returns the latched value.

Moore FSM. Bus outputs decode from the current state only. Outside the bus states: `m_chipselect`=0, `m_write_n`=1, `m_address`=0, `m_writedata`=0.
- OFF: no bus activity. `en`=1 → CTRL_ON.
- CTRL_ON: write address 1, data 16'h0001 → IDLE.
- IDLE: `en`=0 → CTRL_OFF; else `irq`=1 → ACK; else stay. When `en`=0 and `irq`=1 arrive together, `en`=0 wins, no ACK is issued, and the flag stays pending in the timer.
- ACK: write address 0, data 0 → SNAP_WR if the macro is defined, else TICK.
- SNAP_WR: write address 4, data 0 → SNAP_RD.
- SNAP_RD: read address 4 (`m_chipselect`=1, `m_write_n`=1) → SNAP_CAP.
- SNAP_CAP: no access; register `m_readdata` into `snap_value` and set `snap_valid` for the next cycle → TICK.
- TICK: `div_cnt` (16-bit) at TICK_DIV-1 drives `tick`=1, increments `tick_count`, and clears `div_cnt`; otherwise `div_cnt`++. → IDLE.
- CTRL_OFF: write address 1, data 0 → OFF. `div_cnt` is preserved.

Rules:
- Deasserting `en` mid-sequence does not abort the sequence; IDLE acts on it afterwards.
- Re-enabling with the flag still pending produces immediate service after CTRL_ON/IDLE.
- `tick_count` wraps from all-ones to 0 silently.

Reset values: state OFF, `tick`=0, `tick_count`=0, `div_cnt`=0, `busy`=0, `snap_value`=0, `snap_valid`=0, and bus outputs at their idle values. A reset asserted mid-sequence aborts any access; outputs take their reset values in the cycle after the sampling edge.

## Timing
Cycle t is the IDLE cycle in which `irq`=1 and `en`=1.
- Without the macro: ACK write in t+1; TICK in t+2 (`tick` high here when terminal); IDLE in t+3. The new `tick_count` is visible from t+3.
- With the macro: ACK in t+1, SNAP_WR in t+2, SNAP_RD in t+3, SNAP_CAP in t+4 (captures `m_readdata`), TICK in t+5. `snap_valid`=1 and the new `snap_value` appear in t+5.
- `irq` drops in the cycle after the ACK write, so each timeout is counted once. Timeouts merged by the sticky flag count as one.
- `en` 0→1 in OFF: the CTRL_ON write occurs in the next cycle.
- Service throughput: one interrupt per 3 cycles without the macro, 6 with it.

## Configuration
- `TIMER_MASTER_SNAP_EN` defined: SNAP_WR/SNAP_RD/SNAP_CAP are compiled in, and `snap_value`/`snap_valid` are live.
- Not defined: the snapshot states are absent, ACK goes directly to TICK, and `snap_value`=0 and `snap_valid`=0 constantly. The `m_readdata` input is unused.

## Test plan
- Reset with `en`=0 for 10 cycles → all outputs at reset values, `m_chipselect`=0 throughout.
- `en` 0→1 → exactly one write (address 1, data 16'h0001) in the next cycle, then `busy`=0 and no bus traffic.
- TICK_DIV=1, single `irq` at t → write address 0 in t+1, `tick`=1 in t+2, `tick_count` 0→1 at t+3, exactly one ACK.
- TICK_DIV=3, three `irq` services → `tick` asserts only on the third, `tick_count`=1. Then `en`=0 coincident with `irq` in IDLE → write address 1, data 0, no status write, `tick_count` unchanged.
- Macro defined, slave model returns 16'h1234 at address 4 → accesses W4, R4 in t+2/t+3; `snap_value`=16'h1234 and a single-cycle `snap_valid` in t+5.
- Macro defined, `reset_n`=0 sampled during SNAP_RD → next cycle state OFF, `m_chipselect`=0, `snap_valid`=0, `tick_count`=0.
